// File: rtl/mod_inverse_iter.sv
// Iterative modular inverse: extended Euclid, one quotient step per clock.
// Ports: clk, reset (async, active-high), start, a, m -> busy, done,
//   inv_valid, inv; optional gcd output when MOD_INVERSE_GCD_OUT_EN is defined.
module mod_inverse_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] m,
  output logic             busy,
  output logic             done,
  output logic             inv_valid,
  output logic [WIDTH-1:0] inv
`ifdef MOD_INVERSE_GCD_OUT_EN
  ,
  output logic [WIDTH-1:0] gcd
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ITER,
    FIX,
    DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] m_q;
  logic [WIDTH-1:0] r0;
  logic [WIDTH-1:0] r1;
  logic signed [WIDTH:0] t0;
  logic signed [WIDTH:0] t1;

  logic [WIDTH-1:0] div_n;
  logic [WIDTH-1:0] div_d;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;
  logic [WIDTH:0]   prod;
  logic signed [WIDTH:0] t_nxt;
  logic             m_small;

  assign m_small = (m_q <= WIDTH'(1));

  // One divider serves both the a mod m reduction in LOAD and the
  // Euclid quotient in ITER. A zero divisor is never consumed, so
  // it is replaced by 1 only to keep the operator well defined.
  always_comb begin
    div_n = r0;
    div_d = r1;
    if (state == LOAD) begin
      div_n = a_q;
      div_d = m_q;
    end
    if (div_d == '0) begin
      div_d = WIDTH'(1);
    end
  end

  assign quo = div_n / div_d;
  assign rem = div_n % div_d;

  // |t| never exceeds m, so wrapping arithmetic at WIDTH+1 bits
  // yields the exact result even though q*t1 may be wider.
  assign prod  = {1'b0, quo} * $unsigned(t1);
  assign t_nxt = t0 - $signed(prod);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        busy = 1'b1;
        if (m_small) begin
          state_nxt = DONE;
        end else begin
          state_nxt = ITER;
        end
      end
      ITER: begin
        busy = 1'b1;
        if (r1 == '0) begin
          state_nxt = FIX;
        end
      end
      FIX: begin
        busy      = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q       <= '0;
      m_q       <= '0;
      r0        <= '0;
      r1        <= '0;
      t0        <= '0;
      t1        <= '0;
      inv       <= '0;
      inv_valid <= 1'b0;
`ifdef MOD_INVERSE_GCD_OUT_EN
      gcd       <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            a_q <= a;
            m_q <= m;
          end
        end
        LOAD: begin
          r0        <= m_q;
          r1        <= rem;
          t0        <= '0;
          t1        <= (WIDTH+1)'(1);
          inv       <= '0;
          inv_valid <= 1'b0;
`ifdef MOD_INVERSE_GCD_OUT_EN
          // Final value when m <= 1; overwritten in FIX otherwise.
          gcd       <= m_q;
`endif
        end
        ITER: begin
          if (r1 != '0) begin
            r0 <= r1;
            r1 <= rem;
            t0 <= t1;
            t1 <= t_nxt;
          end
        end
        FIX: begin
          if (r0 == WIDTH'(1)) begin
            inv_valid <= 1'b1;
            // Result lies in 0..m-1, so WIDTH-bit wrap is exact.
            inv <= t0[WIDTH-1:0] + (t0[WIDTH] ? m_q : '0);
          end else begin
            inv_valid <= 1'b0;
            inv       <= '0;
          end
`ifdef MOD_INVERSE_GCD_OUT_EN
          gcd <= r0;
`endif
        end
        DONE: begin
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mod_inverse_iter.sv
// Self-checking bench for mod_inverse_iter (WIDTH=32).
// Directed steps with a scoreboard queue of expected results.
module tb_mod_inverse_iter;

  localparam int W = 32;
  localparam int LAT_MAX = 2 * W + 4;

  logic          clk;
  logic          reset;
  logic          start;
  logic [W-1:0]  a;
  logic [W-1:0]  m;
  logic          busy;
  logic          done;
  logic          inv_valid;
  logic [W-1:0]  inv;
`ifdef MOD_INVERSE_GCD_OUT_EN
  logic [W-1:0]  gcd;
`endif

  typedef struct {
    logic         v;
    logic [W-1:0] inv;
    logic [W-1:0] g;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  mod_inverse_iter #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .a         (a),
    .m         (m),
    .busy      (busy),
    .done      (done),
    .inv_valid (inv_valid),
    .inv       (inv)
`ifdef MOD_INVERSE_GCD_OUT_EN
    ,
    .gcd       (gcd)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (done === 1'b1) done_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // Brute-force reference for small moduli.
  task automatic model(input int unsigned ta, input int unsigned tm,
                       output exp_t e);
    int unsigned x;
    int unsigned y;
    int unsigned r;
    e.v = 1'b0;
    e.inv = '0;
    e.g = tm;
    if (tm > 1) begin
      for (int unsigned k = 1; k < tm; k++) begin
        if (((ta % tm) * k) % tm == 1) begin
          e.v = 1'b1;
          e.inv = k;
          break;
        end
      end
      x = tm;
      y = ta % tm;
      while (y != 0) begin
        r = x % y;
        x = y;
        y = r;
      end
      e.g = x;
    end
  endtask

  // Caller is at a negedge; task returns at a negedge.
  task automatic run_op(input string tag, input logic [W-1:0] ta,
                        input logic [W-1:0] tm, input bit hold,
                        input logic ev, input logic [W-1:0] einv,
                        input logic [W-1:0] eg);
    exp_t e;
    exp_t got;
    int cyc;
    int snap;
    e.v = ev;
    e.inv = einv;
    e.g = eg;
    sb.push_back(e);
    snap = done_cnt;
    check({tag, "_idle_busy"}, busy, 0);
    a = ta;
    m = tm;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (!hold) start = 1'b0;
    check({tag, "_busy"}, busy, 1);
    cyc = 1;
    while (done !== 1'b1 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_done_seen"}, done, 1);
    if (tm <= 1) check({tag, "_lat_exact"}, cyc, 2);
    else check({tag, "_lat_bound"}, (cyc <= LAT_MAX), 1);
    check({tag, "_busy_at_done"}, busy, 0);
    got = sb.pop_front();
    check({tag, "_valid"}, inv_valid, got.v);
    check({tag, "_inv"}, inv, got.inv);
`ifdef MOD_INVERSE_GCD_OUT_EN
    check({tag, "_gcd"}, gcd, got.g);
`endif
    @(negedge clk);
    if (hold) start = 1'b0;
    check({tag, "_done_pulse"}, done, 0);
    check({tag, "_hold_valid"}, inv_valid, got.v);
    check({tag, "_hold_inv"}, inv, got.inv);
    check({tag, "_done_count"}, done_cnt - snap, 1);
  endtask

  initial begin
    exp_t e;
    int snap;
    logic [W-1:0] ra;
    logic [W-1:0] rm;
    reset = 1'b1;
    start = 1'b0;
    a = '0;
    m = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_valid", inv_valid, 0);
    check("rst_inv", inv, 0);
`ifdef MOD_INVERSE_GCD_OUT_EN
    check("rst_gcd", gcd, 0);
`endif
    reset = 1'b0;
    run_op("a3m7", 3, 7, 0, 1, 5, 1);
    run_op("a10m7", 10, 7, 0, 1, 5, 1);
    run_op("a2m94849", 2, 94849, 0, 1, 47425, 1);
    run_op("a6m9", 6, 9, 0, 0, 0, 3);
    run_op("m1", 5, 1, 0, 0, 0, 1);
    run_op("m0", 123, 0, 0, 0, 0, 0);
    run_op("a0m11", 0, 11, 0, 0, 0, 11);
    run_op("a255m256", 255, 256, 0, 1, 255, 1);
    run_op("a2mmax", 2, 32'hFFFF_FFFF, 0, 1, 32'h8000_0000, 1);
    run_op("amaxm", 32'hFFFF_FFFE, 32'hFFFF_FFFF, 0, 1,
           32'hFFFF_FFFE, 1);
    run_op("hold", 3, 7, 1, 1, 5, 1);

    // Abort mid-operation.
    snap = done_cnt;
    a = 2;
    m = 94849;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_valid", inv_valid, 0);
    check("abort_inv", inv, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (100) @(negedge clk);
    check("abort_no_done", done_cnt - snap, 0);
    check("abort_idle", busy, 0);
    run_op("post_abort", 3, 7, 0, 1, 5, 1);

    for (int i = 0; i < 6; i++) begin
      rm = $urandom_range(300, 2);
      ra = $urandom_range(600, 0);
      model(ra, rm, e);
      run_op("rand", ra, rm, 0, e.v, e.inv, e.g);
    end

    check("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
